// File: rtl/ede_pkg.sv
// Shared constants and types for the ede waveform filter and its frame reader.
package ede_pkg;

  localparam int FRAME_LEN   = 2400;
  localparam int KERNEL_GAIN = 64;
  localparam int NORM_SHIFT  = $clog2(KERNEL_GAIN);
  localparam int IN_W        = 16;
  localparam int OUT_W       = 10;
  localparam int ADDR_W      = 12;

  typedef logic [IN_W-1:0]   sample_t;
  typedef logic [IN_W:0]     wide_t;
  typedef logic [OUT_W-1:0]  word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  localparam wide_t ROUND_BIAS  = wide_t'(1 << (NORM_SHIFT - 1));
  localparam wide_t NORM_LIMIT  = wide_t'((1 << OUT_W) - 1);
  localparam word_t OUT_MAX     = word_t'((1 << OUT_W) - 1);
  localparam addr_t FRAME_LEN_A = addr_t'(FRAME_LEN);
  localparam addr_t LAST_IDX    = addr_t'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  // Removes the kernel gain with round-half-up; one extra bit keeps the carry.
  function automatic wide_t normalise(input sample_t s);
    wide_t sum;
    sum = {1'b0, s} + ROUND_BIAS;
    return sum >> NORM_SHIFT;
  endfunction

endpackage

// File: rtl/ede_wf_reader_if.sv
// Sample stream and readout bus between the ede filter side and the frame reader.
interface ede_wf_reader_if;
  import ede_pkg::*;

  sample_t iWF;
  logic    iWF_VALID;
  logic    iRD_EN;
  addr_t   iRD_ADDR;
  word_t   oRD_DATA;
  logic    oRD_VALID;

  modport master (
    output iWF, iWF_VALID, iRD_EN, iRD_ADDR,
    input  oRD_DATA, oRD_VALID
  );

  modport slave (
    input  iWF, iWF_VALID, iRD_EN, iRD_ADDR,
    output oRD_DATA, oRD_VALID
  );

endinterface

// File: rtl/ede_frame_ram.sv
// One frame of normalised samples: synchronous write port, registered read port.
module ede_frame_ram
  import ede_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  wr_en,
  input  addr_t wr_addr,
  input  word_t wr_data,
  input  logic  rd_en,
  input  addr_t rd_addr,
  output word_t rd_data
);

  word_t mem [FRAME_LEN];

  // Store accepted samples; the array itself is never cleared.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read register only updates on a request so the last word holds otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ede_wf_reader.sv
// Frame capture, gain removal, peak tracking and random-access readout for the ede filter output.
module ede_wf_reader
  import ede_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  iSTART,
  ede_wf_reader_if.slave        bus,
  output logic                  oBUSY,
  output logic                  oDONE,
  output word_t                 oPEAK_VAL,
  output addr_t                 oPEAK_IDX,
  output logic                  oOVF
);

  state_t state;
  addr_t  wr_ptr;
  logic   rd_valid;
  logic   rd_oob;
  wide_t  norm;
  word_t  norm_sat;
  logic   norm_ovf;
  logic   accept;
  logic   start;
  logic   rd_issue;
  logic   ram_rd_en;
  word_t  ram_q;

  // Normalise and saturate the incoming sample, and decode this cycle's actions.
  always_comb begin
    norm      = normalise(bus.iWF);
    norm_ovf  = norm > NORM_LIMIT;
    norm_sat  = norm_ovf ? OUT_MAX : norm[OUT_W-1:0];
    accept    = (state == CAPTURE) && bus.iWF_VALID;
    start     = iSTART && (state != CAPTURE);
    rd_issue  = (state == DONE) && bus.iRD_EN && !iSTART;
    ram_rd_en = rd_issue && (bus.iRD_ADDR < FRAME_LEN_A);
  end

  // Frame state machine with pointer, peak/overflow tracking and read-valid register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      oPEAK_VAL <= '0;
      oPEAK_IDX <= '0;
      oOVF      <= 1'b0;
      rd_valid  <= 1'b0;
      rd_oob    <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (start) begin
        state     <= CAPTURE;
        wr_ptr    <= '0;
        oPEAK_VAL <= '0;
        oPEAK_IDX <= '0;
        oOVF      <= 1'b0;
      end else begin
        case (state)
          CAPTURE: begin
            if (accept) begin
              if (norm_ovf) oOVF <= 1'b1;
              if (norm_sat > oPEAK_VAL) begin
                oPEAK_VAL <= norm_sat;
                oPEAK_IDX <= wr_ptr;
              end
              wr_ptr <= wr_ptr + 1'b1;
              if (wr_ptr == LAST_IDX) state <= DONE;
            end
          end
          DONE: begin
            if (rd_issue) begin
              rd_valid <= 1'b1;
              rd_oob   <= !(bus.iRD_ADDR < FRAME_LEN_A);
            end
          end
          IDLE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  ede_frame_ram u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (accept),
    .wr_addr (wr_ptr),
    .wr_data (norm_sat),
    .rd_en   (ram_rd_en),
    .rd_addr (bus.iRD_ADDR),
    .rd_data (ram_q)
  );

  assign oBUSY         = (state == CAPTURE);
  assign oDONE         = (state == DONE);
  assign bus.oRD_VALID = rd_valid;
  assign bus.oRD_DATA  = rd_oob ? '0 : ram_q;

endmodule
